// File: rtl/pat_mem_loader_pkg.sv
// Shared constants, state encoding and word-slicing helper for the pattern memory loader.
// Pure declarations: no timing of its own.
// No flow control of its own.
package pat_mem_loader_pkg;

  localparam int PIX_W           = 24;
  localparam int PIX_PER_GROUP   = 32;
  localparam int WORDS_PER_GROUP = 3;
  localparam int MEM_DW          = 256;
  localparam int MEM_AW          = 11;
  localparam int MEM_BE_W        = MEM_DW / 8;
  localparam int GROUP_W         = PIX_W * PIX_PER_GROUP;
  localparam int CNT_W           = $clog2(PIX_PER_GROUP);

  localparam logic [7:0] MARKER_BYTE = 8'h77;

  // ST_FINISH doubles as the marker-write state when the marker build is used.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCEPT = 2'd1,
    ST_WRITE  = 2'd2,
    ST_FINISH = 2'd3
  } state_e;

  // Word 0 is the most significant 256 bits of the group, word 2 the least.
  function automatic logic [MEM_DW-1:0] group_word(input logic [GROUP_W-1:0] grp,
                                                   input logic [1:0]         idx);
    int top;
    top = GROUP_W - 1 - MEM_DW * int'(idx);
    return grp[top -: MEM_DW];
  endfunction

endpackage

// File: rtl/pat_group_packer.sv
// Packs accepted 24-bit pixels into a 768-bit group, pixel 0 in the top slot.
// Latency: a loaded pixel is visible on grp the cycle after it is loaded.
// No backpressure: the caller decides when to load and when to clear.
module pat_group_packer
  import pat_mem_loader_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clear,
  input  logic               load,
  input  logic [PIX_W-1:0]   pix,
  output logic [GROUP_W-1:0] grp,
  output logic               last_slot
);

  logic [GROUP_W-1:0] grp_q, grp_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  // Clear wins over load so an overflowing closing pixel leaves an empty group behind.
  always_comb begin
    grp_d = grp_q;
    cnt_d = cnt_q;
    if (clear) begin
      grp_d = '0;
      cnt_d = '0;
    end else if (load) begin
      for (int k = 0; k < PIX_PER_GROUP; k++) begin
        if (cnt_q == CNT_W'(k)) begin
          grp_d[GROUP_W-1-PIX_W*k -: PIX_W] = pix;
        end
      end
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Group register and pixel count, cleared by the synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      grp_q <= '0;
      cnt_q <= '0;
    end else begin
      grp_q <= grp_d;
      cnt_q <= cnt_d;
    end
  end

  assign grp       = grp_q;
  assign last_slot = (cnt_q == CNT_W'(PIX_PER_GROUP - 1));

endmodule

// File: rtl/pat_mem_loader.sv
// Loads a frame of RGB pixels into on-chip memory as 3x256-bit words per 32-pixel group.
// Latency: closing pixel at N, writes at N+1..N+3, pix_ready again at N+4; done 1 cycle after last write.
// Backpressure: pix_ready drops while a group is written. Build option: PAT_LOADER_MARKER_EN adds a marker word.
module pat_mem_loader
  import pat_mem_loader_pkg::*;
#(
  parameter logic [10:0] BASE_ADDR   = 11'd0,
  parameter logic [10:0] MAX_ADDR    = 11'd2045,
  parameter logic [10:0] MARKER_ADDR = 11'd2047
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic         pix_valid,
  output logic         pix_ready,
  input  logic [23:0]  pix_data,
  input  logic         pix_last,
  output logic         onchip_mem_chip_select,
  output logic         onchip_mem_write,
  output logic [10:0]  onchip_mem_addr,
  output logic [31:0]  onchip_mem_byte_enable,
  output logic [255:0] onchip_mem_write_data,
  output logic         busy,
  output logic         done,
  output logic         overflow
);

  // Highest word a group may touch. The marker word is kept out of the pixel region so
  // enabling the marker never changes which groups fit.
  localparam logic [MEM_AW:0] PIX_CEIL = (MARKER_ADDR > MAX_ADDR) ? {1'b0, MAX_ADDR}
                                                                  : {1'b0, MARKER_ADDR} - 1'b1;

  state_e            state_q, state_d;
  logic [MEM_AW-1:0] addr_q, addr_d;
  logic [1:0]        wcnt_q, wcnt_d;
  logic              busy_q, busy_d;
  logic              ovf_q, ovf_d;
  logic              last_q, last_d;

  logic               pk_clear, pk_load;
  logic [GROUP_W-1:0] grp;
  logic               last_slot;
  logic               closes;
  logic               no_room;

  logic               mem_cs_c, mem_wr_c, done_c;
  logic [MEM_AW-1:0]  mem_addr_c;
  logic [MEM_BE_W-1:0] mem_be_c;
  logic [MEM_DW-1:0]  mem_data_c;

  pat_group_packer u_packer (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (pk_clear),
    .load      (pk_load),
    .pix       (pix_data),
    .grp       (grp),
    .last_slot (last_slot)
  );

  assign closes  = last_slot | pix_last;
  // Widened by one bit so the room check itself can never wrap.
  assign no_room = ({1'b0, addr_q} + (MEM_AW+1)'(WORDS_PER_GROUP - 1)) > PIX_CEIL;

  // Next-state, address and memory-port decode; memory outputs stay zero outside a write.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    wcnt_d     = wcnt_q;
    busy_d     = busy_q;
    ovf_d      = ovf_q;
    last_d     = last_q;
    pk_clear   = 1'b0;
    pk_load    = 1'b0;
    mem_cs_c   = 1'b0;
    mem_wr_c   = 1'b0;
    mem_addr_c = '0;
    mem_be_c   = '0;
    mem_data_c = '0;
    done_c     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d  = ST_ACCEPT;
          addr_d   = BASE_ADDR;
          wcnt_d   = '0;
          busy_d   = 1'b1;
          ovf_d    = 1'b0;
          last_d   = 1'b0;
          pk_clear = 1'b1;
        end
      end

      ST_ACCEPT: begin
        if (pix_valid) begin
          if (ovf_q) begin
            // Out of room: swallow pixels until the frame ends.
            if (pix_last) state_d = ST_FINISH;
          end else begin
            pk_load = 1'b1;
            if (closes) begin
              if (no_room) begin
                ovf_d    = 1'b1;
                pk_clear = 1'b1;
                if (pix_last) state_d = ST_FINISH;
              end else begin
                state_d = ST_WRITE;
                wcnt_d  = '0;
                last_d  = pix_last;
              end
            end
          end
        end
      end

      ST_WRITE: begin
        mem_cs_c   = 1'b1;
        mem_wr_c   = 1'b1;
        mem_be_c   = {MEM_BE_W{1'b1}};
        mem_addr_c = addr_q + MEM_AW'(wcnt_q);
        mem_data_c = group_word(grp, wcnt_q);
        if (wcnt_q == 2'(WORDS_PER_GROUP - 1)) begin
          wcnt_d   = '0;
          addr_d   = addr_q + MEM_AW'(WORDS_PER_GROUP);
          pk_clear = 1'b1;
          state_d  = last_q ? ST_FINISH : ST_ACCEPT;
        end else begin
          wcnt_d = wcnt_q + 1'b1;
        end
      end

      ST_FINISH: begin
`ifdef PAT_LOADER_MARKER_EN
        // First cycle writes the marker word, second cycle signals done.
        if (wcnt_q == 2'd0) begin
          mem_cs_c   = 1'b1;
          mem_wr_c   = 1'b1;
          mem_be_c   = {MEM_BE_W{1'b1}};
          mem_addr_c = MARKER_ADDR;
          mem_data_c = {{(MEM_DW-8){1'b0}}, MARKER_BYTE};
          wcnt_d     = 2'd1;
        end else begin
          done_c  = 1'b1;
          busy_d  = 1'b0;
          wcnt_d  = '0;
          state_d = ST_IDLE;
        end
`else
        done_c  = 1'b1;
        busy_d  = 1'b0;
        state_d = ST_IDLE;
`endif
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // Control state; reset aborts any frame in flight without a done pulse.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      wcnt_q  <= '0;
      busy_q  <= 1'b0;
      ovf_q   <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wcnt_q  <= wcnt_d;
      busy_q  <= busy_d;
      ovf_q   <= ovf_d;
      last_q  <= last_d;
    end
  end

  assign pix_ready              = (state_q == ST_ACCEPT);
  assign busy                   = busy_q;
  assign overflow               = ovf_q;
  assign done                   = done_c;
  assign onchip_mem_chip_select = mem_cs_c;
  assign onchip_mem_write       = mem_wr_c;
  assign onchip_mem_addr        = mem_addr_c;
  assign onchip_mem_byte_enable = mem_be_c;
  assign onchip_mem_write_data  = mem_data_c;

endmodule

// File: tb/tb_pat_mem_loader.sv
// Self-checking bench for pat_mem_loader: directed and random frames against a group-level model.
// Runs with MAX_ADDR = 5 so two groups fit and the third overflows.
// Honours PAT_LOADER_MARKER_EN in its expectations.
module tb_pat_mem_loader;

  localparam logic [10:0] T_BASE = 11'd0;
  localparam logic [10:0] T_MAX  = 11'd5;
  localparam logic [10:0] T_MARK = 11'd2047;
`ifdef PAT_LOADER_MARKER_EN
  localparam bit MARKER = 1'b1;
`else
  localparam bit MARKER = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n, start, pix_valid, pix_last;
  logic [23:0]  pix_data;
  logic         pix_ready, cs, wr, busy, done, overflow;
  logic [10:0]  addr;
  logic [31:0]  be;
  logic [255:0] wdata;

  pat_mem_loader #(.BASE_ADDR(T_BASE), .MAX_ADDR(T_MAX), .MARKER_ADDR(T_MARK)) dut (
    .clk                    (clk),
    .rst_n                  (rst_n),
    .start                  (start),
    .pix_valid              (pix_valid),
    .pix_ready              (pix_ready),
    .pix_data               (pix_data),
    .pix_last               (pix_last),
    .onchip_mem_chip_select (cs),
    .onchip_mem_write       (wr),
    .onchip_mem_addr        (addr),
    .onchip_mem_byte_enable (be),
    .onchip_mem_write_data  (wdata),
    .busy                   (busy),
    .done                   (done),
    .overflow               (overflow)
  );

  typedef struct packed {
    logic [10:0]  a;
    logic [255:0] d;
  } wr_t;

  wr_t got_q[$];
  wr_t exp_q[$];
  int  runs_q[$];
  int  cyc = 0, last_acc = -10, last_wr = -10, done_cyc = -10;
  int  done_cnt = 0, lat_bad = 0, out_bad = 0, run = 0;
  logic prev_wr = 1'b0;

  int vectors = 0, miscompares = 0;
  logic [23:0] pix [0:127];
  int  n_pix;
  bit  exp_ovf;
  int  exp_runs;
  int  g0, d0, r0, lb0, ob0;

  // Observer: captures writes, done pulses, pix_ready gaps and port hygiene.
  always @(negedge clk) begin
    if (pix_valid && pix_ready) last_acc = cyc;
    if (wr) begin
      got_q.push_back(wr_t'{addr, wdata});
      if (!prev_wr && cyc != last_acc + 1) lat_bad++;
      if (!cs || be != 32'hFFFF_FFFF) out_bad++;
      last_wr = cyc;
    end else if (cs || addr != 11'd0 || be != 32'd0 || wdata != 256'd0) begin
      out_bad++;
    end
    prev_wr = wr;
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (!busy) run = 0;
    else if (!pix_ready) run++;
    else begin
      if (run > 0) runs_q.push_back(run);
      run = 0;
    end
    cyc++;
  end

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: chop the frame into 32-pixel groups, place each at BASE+3g while it fits.
  task automatic model();
    logic [767:0] grp;
    logic [11:0]  a;
    int written;
    exp_q.delete();
    exp_ovf = 1'b0;
    written = 0;
    a = {1'b0, T_BASE};
    for (int g = 0; g * 32 < n_pix; g++) begin
      if (a + 12'd2 > {1'b0, T_MAX}) begin
        exp_ovf = 1'b1;
        break;
      end
      grp = '0;
      for (int k = 0; k < 32; k++)
        if (g * 32 + k < n_pix) grp[767 - 24 * k -: 24] = pix[g * 32 + k];
      for (int w = 0; w < 3; w++)
        exp_q.push_back(wr_t'{a[10:0] + 11'(w), grp[767 - 256 * w -: 256]});
      a = a + 12'd3;
      written++;
    end
    if (MARKER) exp_q.push_back(wr_t'{T_MARK, 256'h77});
    exp_runs = exp_ovf ? written : written - 1;
  endtask

  task automatic start_frame();
    g0 = got_q.size(); d0 = done_cnt; r0 = runs_q.size(); lb0 = lat_bad; ob0 = out_bad;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("busy_after_start", busy, 1);
    chk("ovf_clear_on_start", overflow, 0);
    chk("ready_after_start", pix_ready, 1);
  endtask

  // mode 0: valid every cycle, 1: every other cycle, 2: random.
  task automatic drive(input int mode);
    int i = 0, k = 0;
    logic acc;
    while (i < n_pix && k < n_pix * 6 + 50) begin
      case (mode)
        0:       pix_valid = 1'b1;
        1:       pix_valid = (k % 2 == 0);
        default: pix_valid = 1'($urandom_range(0, 1));
      endcase
      pix_data = pix[i];
      pix_last = (i == n_pix - 1);
      @(negedge clk);
      acc = pix_valid && pix_ready;
      tick();
      if (acc) i++;
      k++;
    end
    pix_valid = 1'b0; pix_last = 1'b0; pix_data = '0;
    chk("drive_complete", i, n_pix);
  endtask

  task automatic wait_done();
    int k = 0;
    while (done_cnt == d0 && k < 60) begin
      tick();
      k++;
    end
    chk("done_seen", done_cnt != d0, 1);
    repeat (3) tick();
  endtask

  task automatic check_frame(input string tag);
    int ng, n;
    ng = got_q.size() - g0;
    chk({tag, "_nwrites"}, ng, exp_q.size());
    n = (ng < exp_q.size()) ? ng : exp_q.size();
    for (int i = 0; i < n; i++) begin
      chk($sformatf("%s_addr%0d", tag, i), got_q[g0 + i].a, exp_q[i].a);
      chk($sformatf("%s_data%0d", tag, i), got_q[g0 + i].d, exp_q[i].d);
    end
    chk({tag, "_done_once"}, done_cnt - d0, 1);
    chk({tag, "_overflow"}, overflow, exp_ovf);
    chk({tag, "_busy_idle"}, busy, 0);
    chk({tag, "_nstalls"}, runs_q.size() - r0, exp_runs);
    for (int i = r0; i < runs_q.size(); i++)
      chk($sformatf("%s_stall%0d", tag, i - r0), runs_q[i], 3);
    chk({tag, "_latency"}, lat_bad - lb0, 0);
    chk({tag, "_idle_ports"}, out_bad - ob0, 0);
    if (exp_q.size() > 0 && (!exp_ovf || MARKER))
      chk({tag, "_done_timing"}, done_cyc, last_wr + 1);
  endtask

  task automatic run_frame(input string tag, input int mode);
    start_frame();
    drive(mode);
    wait_done();
    model();
    check_frame(tag);
  endtask

  initial begin
    bit found;
    rst_n = 1'b0; start = 1'b0; pix_valid = 1'b0; pix_last = 1'b0; pix_data = '0;
    repeat (3) tick();
    chk("rst_ready", pix_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_cs", cs, 0);
    chk("rst_wr", wr, 0);
    chk("rst_addr", addr, 0);
    chk("rst_be", be, 0);
    chk("rst_data", wdata, 0);
    rst_n = 1'b1;
    repeat (2) tick();

    // Ramp of 32 pixels.
    n_pix = 32;
    for (int i = 0; i < 32; i++) pix[i] = 24'(i + 1);
    run_frame("ramp32", 0);
    if (got_q.size() >= g0 + 3) begin
      chk("ramp32_w0_top", got_q[g0].d[255:232], 24'h000001);
      chk("ramp32_w2_low", got_q[g0 + 2].d[23:0], 24'h000020);
    end

    // Short frame: 5 pixels, remaining slots zero.
    n_pix = 5;
    for (int i = 0; i < 5; i++) pix[i] = 24'($urandom);
    run_frame("short5", 0);
    if (got_q.size() >= g0 + 3) begin
      chk("short5_w0_pad", got_q[g0].d[135:0], 0);
      chk("short5_w1_zero", got_q[g0 + 1].d, 0);
    end

    // 64 pixels with valid toggling.
    n_pix = 64;
    for (int i = 0; i < 64; i++) pix[i] = 24'($urandom);
    run_frame("toggle64", 1);

    // 96 pixels: third group has no room.
    n_pix = 96;
    for (int i = 0; i < 96; i++) pix[i] = 24'($urandom);
    run_frame("ovf96", 0);
    chk("ovf96_sticky", overflow, 1);

    // Reset in the cycle of the word-1 write.
    start_frame();
    n_pix = 32;
    for (int i = 0; i < 32; i++) pix[i] = 24'($urandom);
    drive(0);
    found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      @(negedge clk);
      if (wr && addr == T_BASE + 11'd1) found = 1'b1;
    end
    chk("rst_window_found", found, 1);
    rst_n = 1'b0;
    tick();
    chk("midrst_wr", wr, 0);
    chk("midrst_cs", cs, 0);
    chk("midrst_addr", addr, 0);
    chk("midrst_be", be, 0);
    chk("midrst_data", wdata, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_ready", pix_ready, 0);
    chk("midrst_done", done, 0);
    rst_n = 1'b1;
    d0 = done_cnt;
    repeat (10) tick();
    chk("midrst_no_done", done_cnt - d0, 0);
    n_pix = 5;
    for (int i = 0; i < 5; i++) pix[i] = 24'($urandom);
    run_frame("after_rst", 2);

    // Random frames.
    for (int f = 0; f < 8; f++) begin
      n_pix = $urandom_range(1, 100);
      for (int i = 0; i < n_pix; i++) pix[i] = 24'($urandom);
      run_frame($sformatf("rand%0d", f), $urandom_range(0, 2));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
